led_display_row_driver: RTL and testbench
=========================================

# led_display_row_driver

Downstream stage of the RAM row loader: accepts one `rgb_row_t` (64 columns × upper/lower RGB = 384 bits) per handshake and drives the HUB75 panel pins. It serially shifts the row into the panel, blanks, latches, sets the row address, then enables the LEDs for a fixed on-time. When done it requests the next row. One row is handled at a time; there is no buffering beyond the captured row.

## Interface

Parameters:
- `CLK_DIV`, 2: system cycles per half-period of `hub_clk_out` (≥1).
- `BLANK_CYCLES`, 4: cycles with OE deasserted before latch (≥1).
- `ON_CYCLES`, 1024: cycles with OE asserted per row (≥1).

Ports:
- `clk_in`, in, 1: single system clock.
- `n_reset_in`, in, 1: reset; asynchronous, active-low.
- `row_in`, in, `rgb_row_t`: row pixel data; valid with `row_valid_in`.
- `row_valid_in`, in, 1: row offered.
- `row_address_in`, in, 4: panel row pair index for `row_in`.
- `row_ready_out`, out, 1: block can accept a row.
- `hub_clk_out`, out, 1: panel shift clock; panel samples on rising edge.
- `hub_lat_out`, out, 1: panel latch strobe, active high.
- `hub_oe_n_out`, out, 1: panel output enable, active low.
- `hub_addr_out`, out, 4: panel row address.
- `hub_rgb_out`, out, 6: `{r0,g0,b0,r1,g1,b1}` for the current column.

## Operation

- Column c (0..63) occupies `row_in[GL_RGB_ROW_W-1-6c -: 6]`. Column 0 is shifted first.
- Transfer rule: a transfer occurs on an edge where `row_valid_in && row_ready_out`. On that edge the row and address are captured into internal registers. `row_valid_in` while not ready is ignored.
- `row_ready_out` = (state == SS_IDLE). It is decoded from the registered state.
- States:
  - SS_IDLE: OE high, `hub_clk` low. On transfer, go to SS_SHIFT with column=0 and phase=0.
  - SS_SHIFT: `hub_rgb_out` holds the current column. `hub_clk_out` is low for CLK_DIV cycles, then high for CLK_DIV cycles. At the end of the high phase the column increments and the captured buffer shifts left by 6. After column 63's high phase, go to SS_BLANK.
  - SS_BLANK: `hub_clk_out` low, `hub_oe_n_out`=1. Lasts BLANK_CYCLES, then go to SS_LATCH.
  - SS_LATCH: one cycle with `hub_lat_out`=1. `hub_addr_out` is loaded with the captured address in this same cycle. Then go to SS_DISPLAY.
  - SS_DISPLAY: `hub_oe_n_out`=0 for ON_CYCLES cycles, then go to SS_IDLE with OE returning high.
- `hub_addr_out` and `hub_rgb_out` hold their values outside the states that update them.
- Counters:
  - column: 6 bits.
  - phase: `$clog2(CLK_DIV)` bits, minimum 1.
  - wait counter: wide enough for `max(BLANK_CYCLES, ON_CYCLES)`.
  - All counters clear on state entry and never wrap within a state.

## Timing

- All panel outputs are driven from flops. No combinational path runs from inputs to outputs. `row_ready_out` is state-decoded only.
- Reset values (applied immediately on `n_reset_in` low, regardless of state):
  - state SS_IDLE, so `row_ready_out`=1.
  - `hub_clk_out`=0, `hub_lat_out`=0, `hub_oe_n_out`=1, `hub_addr_out`=0, `hub_rgb_out`=0.
  - Captured row and address = 0.
- Transfer at edge k:
  - Edge k+1: `row_ready_out`=0, `hub_rgb_out` = column 0, `hub_clk_out`=0.
  - First rising `hub_clk_out` at k+1+CLK_DIV.
- SS_SHIFT lasts 128·CLK_DIV cycles. The 64th rising edge of `hub_clk_out` is the last.
- Full row period, transfer to next `row_ready_out`=1: 128·CLK_DIV + BLANK_CYCLES + 1 + ON_CYCLES cycles.
- `hub_lat_out` never overlaps `hub_oe_n_out`=0 or `hub_clk_out`=1.
- Reset asserted mid-row: OE goes high asynchronously and the row is discarded. After release the block is ready again; the first transfer starts from column 0.

## Structure

- Add to `led_display_package`:
  - `GL_PANEL_COLS`=64.
  - `GL_PIXEL_W`=6.
  - `GL_ROW_ADDR_W`=4.
  - The state enum type.
- Sub-module `led_display_tick_gen`: a CLK_DIV prescaler emitting one-cycle `rise`/`fall` strobes while enabled, cleared on disable. SS_SHIFT uses it.

## Test plan

- CLK_DIV=2, BLANK_CYCLES=4, ON_CYCLES=16, row with column c = c[5:0], address 4'd5, one transfer:
  - Exactly 64 `hub_clk_out` rises; the rise-n sample equals n[5:0].
  - Then 4 blank cycles, one `hub_lat_out` pulse with `hub_addr_out`=5.
  - Then 16 cycles of OE low.
  - Ready returns after 277 cycles.
- Two back-to-back rows from a model of the RAM row loader (one-cycle valid pulses), addresses 0 and 1:
  - Both are displayed in order.
  - No transfer is lost.
  - `hub_addr_out` steps 0→1.
- `row_valid_in` pulsed during SS_SHIFT and SS_DISPLAY:
  - Ignored; the captured data is unchanged.
  - The cycle count is identical to the single-row case.
- CLK_DIV=1, ON_CYCLES=1:
  - `hub_clk_out` toggles every cycle.
  - The period is 128+4+1+1=134 cycles.
  - Latch/OE/clock mutual exclusion holds on every cycle (assertion).
- `n_reset_in` low at column 30:
  - Next cycle all outputs are at reset values and ready=1.
  - After release a new row shifts from column 0 correctly.
- Address 4'hF followed by 4'h0:
  - `hub_addr_out` wraps correctly, with no stale data shifted.

Source files
------------

// File: rtl/led_display_row_driver_pkg.sv
// Shared panel geometry, row type and shift-state encoding for the LED display pipeline.
package led_display_package;

  localparam int GL_PANEL_COLS = 64;
  localparam int GL_PIXEL_W    = 6;
  localparam int GL_ROW_ADDR_W = 4;
  localparam int GL_RGB_ROW_W  = GL_PANEL_COLS * GL_PIXEL_W;

  typedef logic [GL_RGB_ROW_W-1:0] rgb_row_t;

  typedef enum logic [2:0] {
    SS_IDLE,
    SS_SHIFT,
    SS_BLANK,
    SS_LATCH,
    SS_DISPLAY
  } shift_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/led_display_row_driver_tick_gen.sv
// Prescaler for the panel shift clock: one-cycle rise/fall strobes every CLK_DIV cycles while enabled.
module led_display_tick_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  output logic rise,
  output logic fall
);

  localparam int PHASE_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(CLK_DIV - 1);

  logic [PHASE_W-1:0] phase;
  logic               high;
  logic               phase_done;

  assign phase_done = enable && (phase == PHASE_LAST);
  assign rise       = phase_done && !high;
  assign fall       = phase_done && high;

  // Disabling returns the prescaler to the start of a low half-period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase <= '0;
      high  <= 1'b0;
    end else if (!enable) begin
      phase <= '0;
      high  <= 1'b0;
    end else if (phase_done) begin
      phase <= '0;
      high  <= !high;
    end else begin
      phase <= phase + 1'b1;
    end
  end

endmodule

// File: rtl/led_display_row_driver.sv
// HUB75 row driver: shifts one captured 64-column row into the panel, blanks, latches, then lights it.
module led_display_row_driver
  import led_display_package::*;
#(
  parameter int CLK_DIV      = 2,
  parameter int BLANK_CYCLES = 4,
  parameter int ON_CYCLES    = 1024
) (
  input  logic                     clk_in,
  input  logic                     n_reset_in,
  input  rgb_row_t                 row_in,
  input  logic                     row_valid_in,
  input  logic [GL_ROW_ADDR_W-1:0] row_address_in,
  output logic                     row_ready_out,
  output logic                     hub_clk_out,
  output logic                     hub_lat_out,
  output logic                     hub_oe_n_out,
  output logic [GL_ROW_ADDR_W-1:0] hub_addr_out,
  output logic [GL_PIXEL_W-1:0]    hub_rgb_out
);

  localparam int WAIT_W = $clog2(max_int(BLANK_CYCLES, ON_CYCLES) + 1);
  localparam logic [WAIT_W-1:0] BLANK_LAST = WAIT_W'(BLANK_CYCLES - 1);
  localparam logic [WAIT_W-1:0] ON_LAST    = WAIT_W'(ON_CYCLES - 1);
  localparam logic [5:0]        COL_LAST   = 6'(GL_PANEL_COLS - 1);

  shift_state_t               state;
  shift_state_t               state_next;
  rgb_row_t                   row_buf;
  logic [GL_ROW_ADDR_W-1:0]   addr_buf;
  logic [5:0]                 column;
  logic [WAIT_W-1:0]          wait_cnt;
  logic                       tick_rise;
  logic                       tick_fall;
  logic                       transfer;

  assign row_ready_out = (state == SS_IDLE);
  assign transfer      = row_valid_in && row_ready_out;

  led_display_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick_gen (
    .clk    (clk_in),
    .rst_n  (n_reset_in),
    .enable (state == SS_SHIFT),
    .rise   (tick_rise),
    .fall   (tick_fall)
  );

  always_comb begin
    state_next = state;
    case (state)
      SS_IDLE:    if (transfer) state_next = SS_SHIFT;
      SS_SHIFT:   if (tick_fall && column == COL_LAST) state_next = SS_BLANK;
      SS_BLANK:   if (wait_cnt == BLANK_LAST) state_next = SS_LATCH;
      SS_LATCH:   state_next = SS_DISPLAY;
      SS_DISPLAY: if (wait_cnt == ON_LAST) state_next = SS_IDLE;
      default:    state_next = SS_IDLE;
    endcase
  end

  // Counters restart on every state change, so each state sees a fresh count from zero.
  always_ff @(posedge clk_in or negedge n_reset_in) begin
    if (!n_reset_in) begin
      state    <= SS_IDLE;
      column   <= '0;
      wait_cnt <= '0;
    end else begin
      state <= state_next;
      if (state_next != state) begin
        column   <= '0;
        wait_cnt <= '0;
      end else begin
        if (state == SS_SHIFT && tick_fall) column <= column + 1'b1;
        if (state == SS_BLANK || state == SS_DISPLAY) wait_cnt <= wait_cnt + 1'b1;
      end
    end
  end

  // The pixel output always shows the top of the buffer; it holds after the last column.
  always_ff @(posedge clk_in or negedge n_reset_in) begin
    if (!n_reset_in) begin
      row_buf     <= '0;
      addr_buf    <= '0;
      hub_rgb_out <= '0;
    end else if (transfer) begin
      row_buf     <= row_in;
      addr_buf    <= row_address_in;
      hub_rgb_out <= row_in[GL_RGB_ROW_W-1 -: GL_PIXEL_W];
    end else if (state == SS_SHIFT && tick_fall) begin
      row_buf <= row_buf << GL_PIXEL_W;
      if (column != COL_LAST) hub_rgb_out <= row_buf[GL_RGB_ROW_W-1-GL_PIXEL_W -: GL_PIXEL_W];
    end
  end

  // Panel strobes are registered from the next state so they line up with the state register.
  always_ff @(posedge clk_in or negedge n_reset_in) begin
    if (!n_reset_in) begin
      hub_clk_out  <= 1'b0;
      hub_lat_out  <= 1'b0;
      hub_oe_n_out <= 1'b1;
      hub_addr_out <= '0;
    end else begin
      hub_lat_out  <= (state_next == SS_LATCH);
      hub_oe_n_out <= (state_next != SS_DISPLAY);
      if (state_next == SS_LATCH) hub_addr_out <= addr_buf;
      if (state != SS_SHIFT || tick_fall) hub_clk_out <= 1'b0;
      else if (tick_rise) hub_clk_out <= 1'b1;
    end
  end

endmodule

// File: tb/tb_led_display_row_driver.sv
// Bench for led_display_row_driver: two instances (slow and fast shift clock) checked against a timeline model.
module tb_led_display_row_driver;
  import led_display_package::*;

  localparam int N_DUT = 2;
  localparam int BLANK = 4;

  typedef struct packed {
    logic       ready;
    logic       hclk;
    logic       lat;
    logic       oe_n;
    logic [3:0] addr;
    logic [5:0] rgb;
  } outs_t;

  typedef struct {
    int         dut;
    int         kind;
    logic [3:0] addr;
    bit         junk;
    int         exp_period;
    int         exp_rises;
    int         exp_lats;
    logic [3:0] exp_lat_addr;
    int         exp_oe_lows;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  rgb_row_t   row     [N_DUT];
  logic       valid   [N_DUT];
  logic [3:0] addr_in [N_DUT];
  logic       ready   [N_DUT];
  logic       hclk    [N_DUT];
  logic       lat     [N_DUT];
  logic       oe_n    [N_DUT];
  logic [3:0] haddr   [N_DUT];
  logic [5:0] hrgb    [N_DUT];

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  led_display_row_driver #(.CLK_DIV(2), .BLANK_CYCLES(BLANK), .ON_CYCLES(16)) u_dut0 (
    .clk_in (clk), .n_reset_in (rst_n), .row_in (row[0]), .row_valid_in (valid[0]),
    .row_address_in (addr_in[0]), .row_ready_out (ready[0]), .hub_clk_out (hclk[0]),
    .hub_lat_out (lat[0]), .hub_oe_n_out (oe_n[0]), .hub_addr_out (haddr[0]), .hub_rgb_out (hrgb[0])
  );

  led_display_row_driver #(.CLK_DIV(1), .BLANK_CYCLES(BLANK), .ON_CYCLES(1)) u_dut1 (
    .clk_in (clk), .n_reset_in (rst_n), .row_in (row[1]), .row_valid_in (valid[1]),
    .row_address_in (addr_in[1]), .row_ready_out (ready[1]), .hub_clk_out (hclk[1]),
    .hub_lat_out (lat[1]), .hub_oe_n_out (oe_n[1]), .hub_addr_out (haddr[1]), .hub_rgb_out (hrgb[1])
  );

  function automatic int cdiv_of(input int d);
    return (d == 0) ? 2 : 1;
  endfunction

  function automatic int on_of(input int d);
    return (d == 0) ? 16 : 1;
  endfunction

  function automatic int period_of(input int d);
    return 128 * cdiv_of(d) + BLANK + 1 + on_of(d);
  endfunction

  function automatic logic [5:0] pixel(input rgb_row_t r, input int c);
    return r[GL_RGB_ROW_W-1-6*c -: 6];
  endfunction

  function automatic rgb_row_t count_row();
    rgb_row_t r;
    r = '0;
    for (int c = 0; c < 64; c++) r[GL_RGB_ROW_W-1-6*c -: 6] = 6'(c);
    return r;
  endfunction

  function automatic rgb_row_t random_row();
    rgb_row_t r;
    for (int i = 0; i < GL_RGB_ROW_W / 32; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference timeline: everything follows from the transfer cycle and the row offset o.
  bit         m_active    [N_DUT];
  longint     m_xfer      [N_DUT];
  rgb_row_t   m_row       [N_DUT];
  logic [3:0] m_addr      [N_DUT];
  logic [3:0] m_prev_addr [N_DUT];
  longint     cyc = 0;
  bit         mon_en = 1'b0;
  logic [3:0] lat_q [$];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic bit model_busy(input int d);
    return m_active[d] && ((cyc - m_xfer[d]) < longint'(period_of(d)));
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int d = 0; d < N_DUT; d++) begin
        m_active[d]    <= 1'b0;
        m_xfer[d]      <= 0;
        m_row[d]       <= '0;
        m_addr[d]      <= '0;
        m_prev_addr[d] <= '0;
      end
    end else begin
      for (int d = 0; d < N_DUT; d++) begin
        if (valid[d] && !model_busy(d)) begin
          m_active[d]    <= 1'b1;
          m_xfer[d]      <= cyc + 1;
          m_row[d]       <= row[d];
          m_addr[d]      <= addr_in[d];
          m_prev_addr[d] <= m_active[d] ? m_addr[d] : 4'd0;
        end
      end
    end
  end

  function automatic outs_t model_out(input int d);
    outs_t  e;
    longint o;
    int     c;
    int     sh;
    c = cdiv_of(d);
    sh = 128 * c;
    o = cyc - m_xfer[d];
    e.ready = 1'b1; e.hclk = 1'b0; e.lat = 1'b0; e.oe_n = 1'b1; e.addr = 4'd0; e.rgb = 6'd0;
    if (!m_active[d]) return e;
    if (o >= longint'(period_of(d))) begin
      e.addr = m_addr[d];
      e.rgb  = pixel(m_row[d], 63);
      return e;
    end
    e.ready = 1'b0;
    if (o < longint'(sh)) begin
      e.hclk = (o % (2 * c)) >= c;
      e.rgb  = pixel(m_row[d], int'(o / (2 * c)));
      e.addr = m_prev_addr[d];
    end else begin
      e.rgb = pixel(m_row[d], 63);
      if (o < longint'(sh + BLANK)) e.addr = m_prev_addr[d];
      else begin
        e.addr = m_addr[d];
        if (o == longint'(sh + BLANK)) e.lat = 1'b1;
        else e.oe_n = 1'b0;
      end
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      for (int d = 0; d < N_DUT; d++) begin
        check_output($sformatf("timeline d%0d", d),
                     64'({ready[d], hclk[d], lat[d], oe_n[d], haddr[d], hrgb[d]}), 64'(model_out(d)));
        check_output($sformatf("exclusive d%0d", d), 64'(lat[d] && (!oe_n[d] || hclk[d])), 64'd0);
      end
      if (lat[0] === 1'b1) lat_q.push_back(haddr[0]);
    end
  end

  task automatic apply_stimulus(input int d, input rgb_row_t r, input logic [3:0] a, input bit junk,
                                output int period, output int rises, output int rise_bad,
                                output int lats, output logic [3:0] lat_addr, output int oe_lows);
    int   j;
    int   p;
    logic prev_clk;
    p = period_of(d);
    period = -1; rises = 0; rise_bad = 0; lats = 0; lat_addr = '0; oe_lows = 0;
    @(negedge clk);
    #1;
    row[d] = r; addr_in[d] = a; valid[d] = 1'b1;
    @(negedge clk);
    j = 0;
    check_output("first ready", 64'(ready[d]), 64'd0);
    check_output("first hclk", 64'(hclk[d]), 64'd0);
    check_output("first rgb", 64'(hrgb[d]), 64'(pixel(r, 0)));
    prev_clk = hclk[d];
    #1 valid[d] = 1'b0;
    while (!ready[d] && j < p + 50) begin
      @(negedge clk);
      j++;
      if (hclk[d] && !prev_clk) begin
        if (rises < 64 && hrgb[d] !== pixel(r, rises)) rise_bad++;
        rises++;
      end
      prev_clk = hclk[d];
      if (lat[d]) begin lats++; lat_addr = haddr[d]; end
      if (!oe_n[d]) oe_lows++;
      #1;
      valid[d] = junk && (j == 50 || j == p - 1);
      if (valid[d]) begin row[d] = ~r; addr_in[d] = ~a; end
    end
    valid[d] = 1'b0;
    if (ready[d]) period = j;
  endtask

  task automatic run_vec(input vec_t v, input rgb_row_t r);
    int         period, rises, rise_bad, lats, oe_lows;
    logic [3:0] lat_addr;
    apply_stimulus(v.dut, r, v.addr, v.junk, period, rises, rise_bad, lats, lat_addr, oe_lows);
    check_output("period", 64'(period), 64'(v.exp_period));
    check_output("rises", 64'(rises), 64'(v.exp_rises));
    check_output("rise samples", 64'(rise_bad), 64'd0);
    check_output("latch pulses", 64'(lats), 64'(v.exp_lats));
    check_output("latch addr", 64'(lat_addr), 64'(v.exp_lat_addr));
    check_output("oe low cycles", 64'(oe_lows), 64'(v.exp_oe_lows));
  endtask

  vec_t vecs [$];

  initial begin
    vec_t v;
    int   w;
    for (int d = 0; d < N_DUT; d++) begin
      valid[d] = 1'b0; row[d] = '0; addr_in[d] = '0;
    end
    vecs.push_back('{0, 0, 4'h5, 1'b0, 277, 64, 1, 4'h5, 16});
    vecs.push_back('{0, 0, 4'h5, 1'b1, 277, 64, 1, 4'h5, 16});
    vecs.push_back('{0, 1, 4'hF, 1'b0, 277, 64, 1, 4'hF, 16});
    vecs.push_back('{0, 1, 4'h0, 1'b1, 277, 64, 1, 4'h0, 16});
    vecs.push_back('{1, 0, 4'h3, 1'b0, 134, 64, 1, 4'h3, 1});
    vecs.push_back('{1, 1, 4'h9, 1'b1, 134, 64, 1, 4'h9, 1});
    vecs.push_back('{1, 1, 4'hA, 1'b0, 134, 64, 1, 4'hA, 1});
    vecs.push_back('{0, 1, 4'h7, 1'b0, 277, 64, 1, 4'h7, 16});

    repeat (3) @(negedge clk);
    for (int d = 0; d < N_DUT; d++) begin
      check_output("reset state", 64'({ready[d], hclk[d], lat[d], oe_n[d], haddr[d], hrgb[d]}),
                   64'({1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 6'd0}));
    end
    #1;
    mon_en = 1'b1;
    rst_n = 1'b1;

    $display("[TB] table vectors");
    foreach (vecs[i]) run_vec(vecs[i], (vecs[i].kind == 0) ? count_row() : random_row());

    $display("[TB] random rows");
    for (int i = 0; i < 6; i++) begin
      v.dut = int'($urandom_range(0, 1));
      v.kind = 1;
      v.addr = 4'($urandom_range(0, 15));
      v.junk = 1'($urandom_range(0, 1));
      v.exp_period = period_of(v.dut);
      v.exp_rises = 64;
      v.exp_lats = 1;
      v.exp_lat_addr = v.addr;
      v.exp_oe_lows = on_of(v.dut);
      run_vec(v, random_row());
    end

    $display("[TB] reset at column 30");
    @(negedge clk);
    #1;
    row[0] = count_row(); addr_in[0] = 4'h2; valid[0] = 1'b1;
    @(negedge clk);
    #1 valid[0] = 1'b0;
    repeat (120) @(negedge clk);
    check_output("col30 rgb", 64'(hrgb[0]), 64'd30);
    #1 rst_n = 1'b0;
    @(negedge clk);
    check_output("abort state", 64'({ready[0], hclk[0], lat[0], oe_n[0], haddr[0], hrgb[0]}),
                 64'({1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 6'd0}));
    #1 rst_n = 1'b1;
    v = '{0, 0, 4'hC, 1'b0, 277, 64, 1, 4'hC, 16};
    run_vec(v, count_row());

    $display("[TB] back-to-back loader");
    lat_q.delete();
    for (int i = 0; i < 2; i++) begin
      w = 0;
      @(negedge clk);
      while (!ready[0] && w < 1000) begin @(negedge clk); w++; end
      check_output("loader wait", 64'(w < 1000), 64'd1);
      #1;
      row[0] = random_row(); addr_in[0] = 4'(i); valid[0] = 1'b1;
      @(negedge clk);
      #1 valid[0] = 1'b0;
    end
    w = 0;
    while (!ready[0] && w < 1000) begin @(negedge clk); w++; end
    check_output("loader drain", 64'(w < 1000), 64'd1);
    check_output("loader latches", 64'(lat_q.size()), 64'd2);
    if (lat_q.size() == 2) begin
      check_output("loader addr0", 64'(lat_q[0]), 64'd0);
      check_output("loader addr1", 64'(lat_q[1]), 64'd1);
    end

    repeat (4) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
